// File: rtl/rtc_update_pkg.sv
// Shared types and constants for the RTC write-update sequencer.
package rtc_update_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_e;

  localparam int NUM_TGT = 3;

  localparam logic [1:0] SEL_LOAD  = 2'b00;
  localparam logic [1:0] SEL_MATCH = 2'b01;
  localparam logic [1:0] SEL_CTRL  = 2'b10;

  // Entry 0 is the highest priority.
  localparam logic [NUM_TGT-1:0][1:0] PRIO_ORDER = {SEL_MATCH, SEL_LOAD, SEL_CTRL};

endpackage

// File: rtl/rtc_toggle_sync.sv
// Level synchroniser for the ack toggle coming back from the CLK1HZ domain.
module rtc_toggle_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain_q, chain_d;

  always_comb chain_d = {chain_q[SYNC_STAGES-2:0], d};

  always_ff @(posedge clk) begin
    if (rst) chain_q <= '0;
    else     chain_q <= chain_d;
  end

  assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/rtc_update_ctrl.sv
// Captures Load/Match/Ctrl writes, coalesces them per target and ships them one
// at a time to the CLK1HZ domain over a toggle req/ack handshake.
module rtc_update_ctrl
  import rtc_update_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              WrLoad,
  input  logic              WrMatch,
  input  logic              WrCtrl,
  input  logic [DATA_W-1:0] PWDATA,
  output logic              XferReq,
  output logic [1:0]        XferSel,
  output logic [DATA_W-1:0] XferData,
  input  logic              XferAck,
  output logic              Busy,
  output logic [2:0]        Pending,
  output logic              UpdateDone,
  output logic [1:0]        DoneSel
);

  state_e                           state_q, state_d;
  logic                             req_q, req_d;
  logic [1:0]                       sel_q, sel_d;
  logic [DATA_W-1:0]                data_q, data_d;
  logic                             ack_lvl_q, ack_lvl_d;
  logic                             done_q, done_d;
  logic [1:0]                       done_sel_q, done_sel_d;
  logic [NUM_TGT-1:0]               pend_q, pend_d;
  logic [NUM_TGT-1:0][DATA_W-1:0]   hold_q, hold_d;

  logic [NUM_TGT-1:0] wr, pend_clr;
  logic               win_vld;
  logic [1:0]         win_sel;
  logic               ack_sync;

  // Bit index equals the XferSel encoding of each target.
  assign wr = {WrCtrl, WrMatch, WrLoad};

  rtc_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (PCLK),
    .rst (PRESET),
    .d   (XferAck),
    .q   (ack_sync)
  );

  always_comb begin
    win_vld = 1'b0;
    win_sel = SEL_LOAD;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (!win_vld && pend_q[PRIO_ORDER[i]]) begin
        win_vld = 1'b1;
        win_sel = PRIO_ORDER[i];
      end
    end
  end

  always_comb begin
    for (int t = 0; t < NUM_TGT; t++) hold_d[t] = wr[t] ? PWDATA : hold_q[t];
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    sel_d      = sel_q;
    data_d     = data_q;
    ack_lvl_d  = ack_lvl_q;
    done_d     = 1'b0;
    done_sel_d = done_sel_q;
    pend_clr   = '0;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          sel_d             = win_sel;
          data_d            = hold_q[win_sel];
          pend_clr[win_sel] = 1'b1;
          state_d           = LAUNCH;
        end
      end
      LAUNCH: begin
        req_d     = ~req_q;
        ack_lvl_d = ack_sync;
        state_d   = WAIT;
      end
      WAIT: begin
        if (ack_sync != ack_lvl_q) begin
          done_d     = 1'b1;
          done_sel_d = sel_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A strobe landing on the bit being cleared keeps it pending.
    pend_d = (pend_q & ~pend_clr) | wr;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      sel_q      <= SEL_LOAD;
      data_q     <= '0;
      ack_lvl_q  <= 1'b0;
      done_q     <= 1'b0;
      done_sel_q <= SEL_LOAD;
      pend_q     <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      sel_q      <= sel_d;
      data_q     <= data_d;
      ack_lvl_q  <= ack_lvl_d;
      done_q     <= done_d;
      done_sel_q <= done_sel_d;
      pend_q     <= pend_d;
      hold_q     <= hold_d;
    end
  end

  assign XferReq    = req_q;
  assign XferSel    = sel_q;
  assign XferData   = data_q;
  assign Pending    = pend_q;
  assign UpdateDone = done_q;
  assign DoneSel    = done_sel_q;
  // The completion cycle still counts as busy so Busy falls the cycle after it.
  assign Busy       = (state_q != IDLE) || (|pend_q) || done_q;

endmodule

// File: tb/tb_rtc_update_ctrl.sv
// Cycle-stepped bench: directed scenarios plus random writes, all outputs checked
// every cycle against a write-log reference model with a CLK1HZ ack responder.
module tb_rtc_update_ctrl;

  localparam int DATA_W = 32;
  localparam int SYNC   = 2;
  localparam int NEVER  = 32'h7fff_ffff;

  logic              PCLK = 1'b0, PRESET = 1'b1;
  logic              WrLoad = 1'b0, WrMatch = 1'b0, WrCtrl = 1'b0, XferAck = 1'b0;
  logic [DATA_W-1:0] PWDATA = '0;
  logic              XferReq, Busy, UpdateDone;
  logic [1:0]        XferSel, DoneSel;
  logic [DATA_W-1:0] XferData;
  logic [2:0]        Pending;

  rtc_update_ctrl #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .WrLoad(WrLoad), .WrMatch(WrMatch), .WrCtrl(WrCtrl),
    .PWDATA(PWDATA), .XferReq(XferReq), .XferSel(XferSel), .XferData(XferData),
    .XferAck(XferAck), .Busy(Busy), .Pending(Pending), .UpdateDone(UpdateDone),
    .DoneSel(DoneSel)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0, n_bad = 0, cyc = 0, n_done = 0;

  // Model: per target the cycle of its latest write, its value, and the
  // write cycle up to which it has already been shipped.
  int                last_wr[3], cleared[3];
  logic [DATA_W-1:0] val[3];
  int                prio[3] = '{2, 0, 1};
  logic              m_req;
  logic [1:0]        m_sel, m_dsel;
  logic [DATA_W-1:0] m_data;
  int                next_free, latch_cyc, launch_cyc, done_cyc, ack_due;
  bit                ack_en = 1'b1;
  int                dly_lo = 4, dly_hi = 4;
  logic [DATA_W+1:0] sent[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int winner();
    for (int i = 0; i < 3; i++)
      if (last_wr[prio[i]] > cleared[prio[i]]) return prio[i];
    return -1;
  endfunction

  task automatic mreset();
    for (int t = 0; t < 3; t++) begin
      last_wr[t] = -1; cleared[t] = -1; val[t] = '0;
    end
    m_req = 1'b0; m_sel = 2'b00; m_dsel = 2'b00; m_data = '0;
    next_free = 0; latch_cyc = NEVER; launch_cyc = NEVER; done_cyc = NEVER; ack_due = NEVER;
  endtask

  task automatic step(input bit rst, input logic [2:0] wr, input logic [DATA_W-1:0] d);
    logic [2:0] pend;
    bit         busy_exp;
    int         w;
    PRESET = rst;
    {WrCtrl, WrMatch, WrLoad} = rst ? 3'b000 : wr;
    PWDATA = d;
    if (rst) XferAck = 1'b0;
    else if (ack_due == cyc + 1) begin
      XferAck  = ~XferAck;
      done_cyc = cyc + 1 + SYNC;
      ack_due  = NEVER;
    end
    @(posedge PCLK);
    cyc++;
    #1;
    if (rst) mreset();
    else begin
      w = winner();
      if (cyc >= next_free && w >= 0) begin
        m_sel      = 2'(w);
        m_data     = val[w];
        cleared[w] = cyc - 1;
        latch_cyc  = cyc;
        launch_cyc = cyc + 1;
        next_free  = NEVER;
        done_cyc   = NEVER;
      end
      if (cyc == launch_cyc) begin
        m_req = ~m_req;
        sent.push_back({XferSel, XferData});
        if (ack_en) ack_due = cyc + int'($urandom_range(dly_hi, dly_lo));
      end
      for (int t = 0; t < 3; t++)
        if (wr[t]) begin last_wr[t] = cyc; val[t] = d; end
      if (cyc == done_cyc) begin
        m_dsel    = m_sel;
        next_free = cyc + 1;
      end
    end
    for (int t = 0; t < 3; t++) pend[t] = last_wr[t] > cleared[t];
    busy_exp = (cyc >= latch_cyc && cyc <= done_cyc) || (pend != 3'b000);
    if (UpdateDone === 1'b1) n_done++;
    chk("XferReq",    64'(XferReq),    64'(m_req));
    chk("XferSel",    64'(XferSel),    64'(m_sel));
    chk("XferData",   64'(XferData),   64'(m_data));
    chk("Pending",    64'(Pending),    64'(pend));
    chk("Busy",       64'(Busy),       64'(busy_exp));
    chk("UpdateDone", 64'(UpdateDone), 64'(cyc == done_cyc));
    chk("DoneSel",    64'(DoneSel),    64'(m_dsel));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'b000, '0);
  endtask

  initial begin
    int d0;
    mreset();
    step(1'b1, 3'b000, '0);
    step(1'b1, 3'b000, '0);
    idle(2);

    // Single Load, ack 4 cycles after the request toggle
    sent.delete(); d0 = n_done;
    step(1'b0, 3'b001, 32'h0000_1234);
    idle(14);
    chk("A_count", 64'(sent.size()), 64'd1);
    chk("A_xfer",  64'(sent[0]), {30'd0, 2'b00, 32'h1234});
    chk("A_done",  64'(n_done - d0), 64'd1);

    // Match + Ctrl in one cycle share PWDATA, Ctrl goes first
    sent.delete(); d0 = n_done;
    step(1'b0, 3'b110, 32'h1);
    idle(25);
    chk("B_count", 64'(sent.size()), 64'd2);
    chk("B_first", 64'(sent[0]), {30'd0, 2'b10, 32'h1});
    chk("B_next",  64'(sent[1]), {30'd0, 2'b01, 32'h1});
    chk("B_done",  64'(n_done - d0), 64'd2);

    // Three Load writes coalesce while a Match transfer waits
    dly_lo = 8; dly_hi = 8;
    sent.delete();
    step(1'b0, 3'b010, 32'h77);
    idle(3);
    step(1'b0, 3'b001, 32'h1);
    step(1'b0, 3'b001, 32'h2);
    step(1'b0, 3'b001, 32'h3);
    idle(30);
    chk("C_count", 64'(sent.size()), 64'd2);
    chk("C_match", 64'(sent[0]), {30'd0, 2'b01, 32'h77});
    chk("C_load",  64'(sent[1]), {30'd0, 2'b00, 32'h3});

    // Rewrite of the in-flight target is re-sent afterwards
    dly_lo = 6; dly_hi = 6;
    sent.delete();
    step(1'b0, 3'b001, 32'h4);
    step(1'b0, 3'b000, '0);
    step(1'b0, 3'b001, 32'h5);
    idle(30);
    chk("D_count", 64'(sent.size()), 64'd2);
    chk("D_first", 64'(sent[0]), {30'd0, 2'b00, 32'h4});
    chk("D_next",  64'(sent[1]), {30'd0, 2'b00, 32'h5});

    // Withheld ack, then reset abandons the transfer and the pending write
    ack_en = 1'b0; d0 = n_done;
    step(1'b0, 3'b010, 32'h99);
    idle(500);
    step(1'b0, 3'b001, 32'h55);
    idle(500);
    chk("E_nodone", 64'(n_done - d0), 64'd0);
    step(1'b1, 3'b000, '0);
    ack_en = 1'b1;
    idle(3);

    // Strobe coincides with the arbiter clearing the same target
    dly_lo = 4; dly_hi = 4;
    sent.delete();
    step(1'b0, 3'b001, 32'h10);
    step(1'b0, 3'b001, 32'h20);
    idle(30);
    chk("F_count", 64'(sent.size()), 64'd2);
    chk("F_first", 64'(sent[0]), {30'd0, 2'b00, 32'h10});
    chk("F_next",  64'(sent[1]), {30'd0, 2'b00, 32'h20});

    // Random writes, random ack delays, occasional reset
    dly_lo = 1; dly_hi = 6;
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] wr;
      wr = 3'($urandom) & 3'($urandom);
      step($urandom_range(499, 0) == 0, wr, $urandom);
    end
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
